// File: rtl/mux4_sched_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux scheduler.
package mux4_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NREQ = 4;

    // First set request bit, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_w.sv
// Width-parameterised combinational 4:1 mux.
module mux4_w #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        unique case (sel)
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            default: y = i3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler driving a shared 4:1 mux onto a valid/ready channel,
// with each grant bounded to HOLD_MAX accepted words.
//
// state | meaning
// IDLE  | no grant; picks next requester from ptr when any req is set
// GRANT | sel owns the mux; transfers on req[sel] & y_ready
module mux4_rr_scheduler
    import mux4_sched_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [1:0]       sel,
    output logic             busy
);

    localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

    state_t     state, state_n;
    logic [1:0] sel_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] cnt, cnt_n;
    logic       xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        busy    = (state == GRANT);
        y_valid = 1'b0;
        ack     = 4'b0000;
        xfer    = 1'b0;

        unique case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_n   = rr_pick(req, ptr);
                    cnt_n   = 4'd0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                y_valid = req[sel];
                xfer    = req[sel] & y_ready;
                if (xfer)
                    ack = 4'b0001 << sel;
                // A dropped request and a full burst both hand the mux on.
                if (!req[sel] || (xfer && cnt == CNT_LAST)) begin
                    state_n = IDLE;
                    ptr_n   = sel + 2'd1;
                    cnt_n   = 4'd0;
                end else if (xfer) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    mux4_w #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .y   (y)
    );

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler: one HOLD_MAX=4 instance, one HOLD_MAX=1.
module tb_mux4_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] i0, i1, i2, i3;
    logic       y_ready;

    logic [3:0] ack,  ack1;
    logic [7:0] y,    y1;
    logic       y_valid, y_valid1;
    logic [1:0] sel,  sel1;
    logic       busy, busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux4_rr_scheduler #(.WIDTH(8), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .ack(ack), .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .sel(sel), .busy(busy)
    );

    mux4_rr_scheduler #(.WIDTH(8), .HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .ack(ack1), .y(y1), .y_valid(y_valid1), .y_ready(y_ready),
        .sel(sel1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [1:0] order [5];
        logic [1:0] exp_sel;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1; req = 4'b0000; y_ready = 1'b0;
        i0 = 8'h11; i1 = 8'h22; i2 = 8'h33; i3 = 8'h44;

        // 1: reset and idle
        do_reset();
        chk("rst_y_eq_i0", 32'(y), 32'h11);
        chk("rst_ptr", 32'(dut.ptr), 0);
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk("idle_sel", 32'(sel), 0);
            chk("idle_valid", 32'(y_valid), 0);
            chk("idle_ack", 32'(ack), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // 2: single requester, full burst of 4
        do_reset();
        req = 4'b0100; i2 = 8'hA5; y_ready = 1'b1; #1;
        chk("t2_idle_busy", 32'(busy), 0);
        chk("t2_idle_valid", 32'(y_valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("t2_busy", 32'(busy), 1);
            chk("t2_sel", 32'(sel), 2);
            chk("t2_y", 32'(y), 32'hA5);
            chk("t2_valid", 32'(y_valid), 1);
            chk("t2_ack", 32'(ack), 32'b0100);
        end
        tick(); #1;
        chk("t2_exit_busy", 32'(busy), 0);
        chk("t2_exit_ack", 32'(ack), 0);
        chk("t2_exit_ptr", 32'(dut.ptr), 3);
        tick(); #1;
        chk("t2_regrant_sel", 32'(sel), 2);

        // 3: HOLD_MAX=1 strict rotation
        do_reset();
        req = 4'b1111; y_ready = 1'b1; #1;
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 0) begin
                chk("t3_gap_busy", 32'(busy1), 0);
                chk("t3_gap_ack", 32'(ack1), 0);
            end else begin
                exp_sel = order[(c - 1) / 2];
                chk("t3_busy", 32'(busy1), 1);
                chk("t3_sel", 32'(sel1), 32'(exp_sel));
                chk("t3_ack", 32'(ack1), 32'(4'b0001 << exp_sel));
            end
            tick(); #1;
        end

        // 4: stall with y_ready low
        do_reset();
        req = 4'b0011; y_ready = 1'b0;
        tick(); #1;
        for (int k = 0; k < 3; k++) begin
            chk("t4_sel", 32'(sel), 0);
            chk("t4_valid", 32'(y_valid), 1);
            chk("t4_ack", 32'(ack), 0);
            chk("t4_cnt", 32'(dut.cnt), 0);
            tick(); #1;
        end
        y_ready = 1'b1; #1;
        chk("t4_ack_ready", 32'(ack), 32'b0001);
        tick(); #1;
        chk("t4_cnt_after", 32'(dut.cnt), 1);

        // 5: granted requester drops mid-burst
        do_reset();
        req = 4'b0011; y_ready = 1'b1;
        tick(); #1;
        chk("t5_ack0", 32'(ack), 32'b0001);
        tick(); #1;
        chk("t5_ack1", 32'(ack), 32'b0001);
        tick();
        req = 4'b0010; #1;
        chk("t5_drop_valid", 32'(y_valid), 0);
        chk("t5_drop_ack", 32'(ack), 0);
        tick(); #1;
        chk("t5_idle_busy", 32'(busy), 0);
        tick(); #1;
        chk("t5_next_sel", 32'(sel), 1);
        chk("t5_next_ack", 32'(ack), 32'b0010);

        // 6: reset mid-grant
        do_reset();
        req = 4'b1000; y_ready = 1'b1;
        tick(); tick(); tick(); #1;
        chk("t6_pre_sel", 32'(sel), 3);
        chk("t6_pre_cnt", 32'(dut.cnt), 2);
        rst = 1'b1;
        tick(); #1;
        chk("t6_rst_sel", 32'(sel), 0);
        chk("t6_rst_cnt", 32'(dut.cnt), 0);
        chk("t6_rst_ptr", 32'(dut.ptr), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ack", 32'(ack), 0);
        rst = 1'b0;
        tick(); #1;
        chk("t6_resume_busy", 32'(busy), 1);
        chk("t6_resume_sel", 32'(sel), 3);
        chk("t6_resume_ack", 32'(ack), 32'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
